// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EXE.
// Holds the pipeline via stallreq_o until the registered result is written back.
module div_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int CNT_WIDTH   = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [2:0]             funct3_i,
    input  logic [DATA_WIDTH-1:0]  dividend_i,
    input  logic [DATA_WIDTH-1:0]  divisor_i,
    input  logic [RADDR_WIDTH-1:0] rd_i,
    input  logic                   flush_i,
    output logic                   stallreq_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH-1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0]  rem_q, quo_q, dvsr_q, result_q;
    logic [2:0]             funct3_q;
    logic [RADDR_WIDTH-1:0] rd_q;
    logic                   sign_a_q, sign_b_q;

    // Operand decode at accept time
    logic                  is_signed, sign_a, sign_b, div_zero, overflow, accept;
    logic [DATA_WIDTH-1:0] abs_a, abs_b, special_result;

    assign is_signed = ~funct3_i[0];
    assign sign_a    = is_signed & dividend_i[DATA_WIDTH-1];
    assign sign_b    = is_signed & divisor_i[DATA_WIDTH-1];
    assign abs_a     = sign_a ? (~dividend_i + ONE) : dividend_i;
    assign abs_b     = sign_b ? (~divisor_i + ONE) : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign overflow  = is_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);
    assign accept    = (state_q == IDLE) & start_i & ~flush_i;

    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = funct3_i[1] ? dividend_i : '1;
        else if (overflow)
            special_result = funct3_i[1] ? '0 : MIN_NEG;
    end

    // One restoring step; the trial carries two extra bits so the shifted
    // remainder (up to DATA_WIDTH+1 bits) and the borrow are both exact.
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH+1:0] trial;
    logic                  trial_ok, last_iter;
    logic [DATA_WIDTH-1:0] rem_next, quo_next, quo_fix, rem_fix, final_result;

    assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    assign trial     = {1'b0, rem_shift} - {2'b00, dvsr_q};
    assign trial_ok  = ~trial[DATA_WIDTH+1];
    assign rem_next  = trial_ok ? trial[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
    assign quo_next  = {quo_q[DATA_WIDTH-2:0], trial_ok};
    assign last_iter = (cnt_q == LAST_CNT);

    // Sign flags are zero for unsigned ops, so the fixup is a no-op there.
    assign quo_fix      = (sign_a_q ^ sign_b_q) ? (~quo_next + ONE) : quo_next;
    assign rem_fix      = sign_a_q ? (~rem_next + ONE) : rem_next;
    assign final_result = funct3_q[1] ? rem_fix : quo_fix;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (div_zero | overflow) ? DONE : CALC;
            CALC: begin
                if (flush_i)        state_d = IDLE;
                else if (last_iter) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= funct3_i;
                        rd_q     <= rd_i;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        dvsr_q   <= abs_b;
                        quo_q    <= abs_a;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        if (div_zero | overflow)
                            result_q <= special_result;
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        cnt_q <= '0;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (last_iter)
                            result_q <= final_result;
                    end
                end
                DONE:    cnt_q <= '0;
                default: cnt_q <= '0;
            endcase
        end
    end

    assign stallreq_o  = accept | (state_q == CALC);
    assign busy_o      = (state_q == CALC) | (state_q == DONE);
    assign done_o      = (state_q == DONE);
    assign reg_we_o    = done_o;
    assign result_o    = result_q;
    assign reg_waddr_o = rd_q;

endmodule
